// File: rtl/save_write_packer.sv
// Accepts address-filtered APF bridge writes, buffers them as 32-bit entries and
// replays each one as two 16-bit little-endian words on a valid/ready stream.
module save_write_packer #(
    parameter logic [3:0] ADDRESS_MASK_UPPER_4 = 4'h2,
    parameter int         ADDRESS_SIZE         = 18,
    parameter int         FIFO_DEPTH           = 4
) (
    input  logic                    clk_74a,
    input  logic                    reset,
    input  logic                    bridge_wr,
    input  logic                    bridge_endian_little,
    input  logic [31:0]             bridge_addr,
    input  logic [31:0]             bridge_wr_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_SIZE-1:0] out_addr,
    output logic [15:0]             out_data,
    output logic                    overflow,
    output logic                    busy
);

    localparam int HA_W    = ADDRESS_SIZE - 2;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = HA_W + 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    logic [ENTRY_W-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_r;
    logic [PTR_W-1:0]       rptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_s;
    logic                   overflow_r;

    state_t                 state_r;
    state_t                 state_s;
    logic [HA_W-1:0]        ha_r;
    logic [HA_W-1:0]        ha_s;
    logic [31:0]            hd_r;
    logic [31:0]            hd_s;

    logic                   out_valid_r;
    logic                   out_valid_s;
    logic [ADDRESS_SIZE-1:0] out_addr_r;
    logic [ADDRESS_SIZE-1:0] out_addr_s;
    logic [15:0]            out_data_r;
    logic [15:0]            out_data_s;

    logic                   candidate_s;
    logic [31:0]            data_norm_s;
    logic [ENTRY_W-1:0]     entry_s;
    logic [ENTRY_W-1:0]     head_s;
    logic                   fifo_nonempty_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   unused_addr_s;

    assign candidate_s     = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
    assign data_norm_s     = bridge_endian_little ? bridge_wr_data : byte_swap32(bridge_wr_data);
    assign entry_s         = {bridge_addr[ADDRESS_SIZE-1:2], data_norm_s};
    assign head_s          = mem_r[rptr_r];
    assign fifo_nonempty_s = (count_r != {CNT_W{1'b0}});
    // A full FIFO still takes a write when the FSM drains the head in the same cycle.
    assign push_s          = candidate_s && ((count_r != CNT_W'(FIFO_DEPTH)) || pop_s);
    assign unused_addr_s   = ^bridge_addr;

    // FSM next state, hold-register loads, FIFO pop and next output values.
    always_comb begin
        state_s     = state_r;
        ha_s        = ha_r;
        hd_s        = hd_r;
        pop_s       = 1'b0;
        out_valid_s = 1'b0;
        out_addr_s  = {ADDRESS_SIZE{1'b0}};
        out_data_s  = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (fifo_nonempty_s) begin
                    ha_s    = head_s[ENTRY_W-1:32];
                    hd_s    = head_s[31:0];
                    pop_s   = 1'b1;
                    state_s = ST_LO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (out_ready) begin
                    state_s = ST_HI;
                end else begin
                    state_s = ST_LO;
                end
            end
            ST_HI: begin
                if (out_ready && fifo_nonempty_s) begin
                    ha_s    = head_s[ENTRY_W-1:32];
                    hd_s    = head_s[31:0];
                    pop_s   = 1'b1;
                    state_s = ST_LO;
                end else if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HI;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        case (state_s)
            ST_LO: begin
                out_valid_s = 1'b1;
                out_addr_s  = {ha_s, 2'b00};
                out_data_s  = hd_s[15:0];
            end
            ST_HI: begin
                out_valid_s = 1'b1;
                out_addr_s  = {ha_s, 2'b10};
                out_data_s  = hd_s[31:16];
            end
            default: begin
                out_valid_s = 1'b0;
                out_addr_s  = {ADDRESS_SIZE{1'b0}};
                out_data_s  = 16'h0000;
            end
        endcase
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; contents are don't-care until the count says otherwise.
    always_ff @(posedge clk_74a) begin
        if (push_s && !reset) begin
            mem_r[wptr_r] <= entry_s;
        end
    end

    // FIFO pointers, count and sticky overflow flag.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            wptr_r     <= {PTR_W{1'b0}};
            rptr_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
            end
            count_r <= count_s;
            if (candidate_s && !push_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FSM state, hold registers and registered stream outputs.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ha_r        <= {HA_W{1'b0}};
            hd_r        <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_addr_r  <= {ADDRESS_SIZE{1'b0}};
            out_data_r  <= 16'h0000;
        end else begin
            state_r     <= state_s;
            ha_r        <= ha_s;
            hd_r        <= hd_s;
            out_valid_r <= out_valid_s;
            out_addr_r  <= out_addr_s;
            out_data_r  <= out_data_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_data  = out_data_r;
    assign overflow  = overflow_r;
    assign busy      = fifo_nonempty_s || (state_r != ST_IDLE);

endmodule
